iq_read: RTL
============

# iq_read

Front-end unpacker of the FM radio chain. It pulls raw interleaved 8-bit bytes from the input byte FIFO, assembles little-endian signed 16-bit I and Q samples, and quantizes them to fixed-point `DATA_WIDTH` words. It writes each I/Q pair simultaneously into the real and imaginary sample FIFOs consumed by `fir_cmplx`.

## Interface
- `DATA_WIDTH`, 32: width of the output sample words. Must satisfy `DATA_WIDTH >= 16 + QUANT_BITS`.
- `BYTE_WIDTH`, 8: width of the input FIFO word. Fixed at 8.
- `QUANT_BITS`, 10: left-shift applied to each 16-bit sample (multiply by 2^QUANT_BITS).

- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: reset. Asynchronous and active-low.
- `in_dout`, in, `BYTE_WIDTH`: head byte of the input FIFO. Show-ahead: valid whenever `in_empty` is 0.
- `in_empty`, in, 1: input FIFO empty.
- `in_rd_en`, out, 1: pops one byte from the input FIFO.
- `i_out`, out, `DATA_WIDTH`, signed: quantized I sample, goes to the real FIFO `din`.
- `q_out`, out, `DATA_WIDTH`, signed: quantized Q sample, goes to the imaginary FIFO `din`.
- `i_wr_en`, out, 1: write strobe to the real FIFO.
- `q_wr_en`, out, 1: write strobe to the imaginary FIFO. Always equal to `i_wr_en`.
- `i_full`, in, 1: real FIFO full.
- `q_full`, in, 1: imaginary FIFO full.

## Operation
- FSM states: `S_I_LO`, `S_I_HI`, `S_Q_LO`, `S_Q_HI`, `S_WRITE`. Reset state is `S_I_LO`.
- Byte order on the stream: I low, I high, Q low, Q high. The stream repeats with no framing.
- Byte states (`S_I_LO` through `S_Q_HI`):
  - If `in_empty`=0: assert `in_rd_en`, capture `in_dout` into that state's byte register, advance to the next state.
  - If `in_empty`=1: hold state, `in_rd_en`=0.
- On leaving `S_Q_HI`, the sample registers are loaded:
  - `i_out` = sign-extend({I_hi, I_lo}) << QUANT_BITS
  - `q_out` = sign-extend({Q_hi, Q_lo}) << QUANT_BITS
  - Arithmetic shift. Low QUANT_BITS bits are zero. No saturation is needed given the width rule.
- `S_WRITE`:
  - If `i_full`=0 and `q_full`=0: assert `i_wr_en` and `q_wr_en` for exactly one cycle, then return to `S_I_LO`.
  - Otherwise hold with both strobes 0 and the sample registers unchanged.
  - A write never goes to only one of the two FIFOs.
- `in_rd_en` is 0 in `S_WRITE`. No input byte is consumed while a sample is pending.
- `in_rd_en`, `i_wr_en` and `q_wr_en` are combinational from state and the empty/full flags. `i_out` and `q_out` are registered.

## Timing
- Reset values: state `S_I_LO`, all byte registers 0, `i_out`=0, `q_out`=0, `in_rd_en`=0, `i_wr_en`=0, `q_wr_en`=0.
- Reset asserted mid-sample discards any partially assembled bytes. After release, the next byte popped is treated as I low.
- Throughput with the input never empty and the outputs never full: one I/Q pair every 5 cycles.
- Latency: the write strobe occurs in the cycle after the Q-high byte is popped.
- `in_empty` toggling between bytes only stretches the sequence. Byte alignment is never lost.
- Full and empty both asserted simultaneously in `S_WRITE`: hold; no read and no write.
- Full deasserting in the same cycle the FSM enters `S_WRITE`: the write happens in that `S_WRITE` cycle.
- First byte after reset release: popped on the first rising edge with `rst`=1 and `in_empty`=0.

## Test plan
- Input bytes 0x34, 0x12, 0x78, 0x56 with outputs free -> exactly one write with `i_out`=4771840 (0x1234·1024) and `q_out`=22667264 (0x5678·1024).
- Input bytes 0xFF, 0xFF, 0x00, 0x80 -> `i_out`=-1024 and `q_out`=-33554432. Low 10 bits of both are zero.
- `i_full` held at 1 for 10 cycles while in `S_WRITE`:
  - No `i_wr_en` or `q_wr_en` and no `in_rd_en` during those cycles; outputs hold their values.
  - One write occurs on the cycle `i_full` drops.
  - Repeat with `q_full` only.
- `in_empty` pulsed to 1 for 3 cycles between each byte of the pair 0x01, 0x00, 0xFE, 0xFF -> a single write with `i_out`=1024 and `q_out`=-2048.
- Assert `rst`=0 after 2 bytes have been popped, then release and feed 0x02, 0x00, 0x03, 0x00 -> `i_out`=2048 and `q_out`=3072. No write of stale data.
- Stream 256 random pairs with the input always non-empty and the outputs never full:
  - Exactly 256 writes, each matching the software golden model.
  - Writes are spaced exactly 5 cycles apart.
  - `i_wr_en` equals `q_wr_en` on every cycle.

Source files
------------

// File: rtl/iq_read.sv
// iq_read: unpacks interleaved little-endian I/Q byte stream into
// quantized signed DATA_WIDTH samples written to paired I/Q FIFOs.
module iq_read #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int QUANT_BITS = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BYTE_WIDTH-1:0]        in_dout,
    input  logic                         in_empty,
    output logic                         in_rd_en,
    output logic signed [DATA_WIDTH-1:0] i_out,
    output logic signed [DATA_WIDTH-1:0] q_out,
    output logic                         i_wr_en,
    output logic                         q_wr_en,
    input  logic                         i_full,
    input  logic                         q_full
);

    localparam int SAMPLE_WIDTH = 2 * BYTE_WIDTH;

    typedef enum logic [2:0] {
        S_I_LO,
        S_I_HI,
        S_Q_LO,
        S_Q_HI,
        S_WRITE
    } state_t;

    state_t                  r_state;
    logic [BYTE_WIDTH-1:0]   r_i_lo;
    logic [BYTE_WIDTH-1:0]   r_i_hi;
    logic [BYTE_WIDTH-1:0]   r_q_lo;
    logic [DATA_WIDTH-1:0]   r_i_out;
    logic [DATA_WIDTH-1:0]   r_q_out;

    logic                    w_byte_state;
    logic                    w_pop;
    logic                    w_push;
    logic [SAMPLE_WIDTH-1:0] w_i_raw;
    logic [SAMPLE_WIDTH-1:0] w_q_raw;
    logic [DATA_WIDTH-1:0]   w_i_ext;
    logic [DATA_WIDTH-1:0]   w_q_ext;
    logic [DATA_WIDTH-1:0]   w_i_quant;
    logic [DATA_WIDTH-1:0]   w_q_quant;

    // Handshake strobes: pop in any byte state with data, push only when both FIFOs have room
    always_comb begin
        w_byte_state = (r_state != S_WRITE);
        w_pop        = rst & w_byte_state & ~in_empty;
        w_push       = rst & (r_state == S_WRITE) & ~i_full & ~q_full;
    end

    assign in_rd_en = w_pop;
    assign i_wr_en  = w_push;
    assign q_wr_en  = w_push;
    assign i_out    = r_i_out;
    assign q_out    = r_q_out;

    // Sample assembly and quantization; Q high byte is taken straight from the FIFO head
    always_comb begin
        w_i_raw   = {r_i_hi, r_i_lo};
        w_q_raw   = {in_dout, r_q_lo};
        w_i_ext   = {{(DATA_WIDTH-SAMPLE_WIDTH){w_i_raw[SAMPLE_WIDTH-1]}}, w_i_raw};
        w_q_ext   = {{(DATA_WIDTH-SAMPLE_WIDTH){w_q_raw[SAMPLE_WIDTH-1]}}, w_q_raw};
        w_i_quant = w_i_ext << QUANT_BITS;
        w_q_quant = w_q_ext << QUANT_BITS;
    end

    // Byte-sequencing FSM with byte and sample registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_I_LO;
            r_i_lo  <= '0;
            r_i_hi  <= '0;
            r_q_lo  <= '0;
            r_i_out <= '0;
            r_q_out <= '0;
        end else begin
            case (r_state)
                S_I_LO: if (!in_empty) begin
                    r_i_lo  <= in_dout;
                    r_state <= S_I_HI;
                end
                S_I_HI: if (!in_empty) begin
                    r_i_hi  <= in_dout;
                    r_state <= S_Q_LO;
                end
                S_Q_LO: if (!in_empty) begin
                    r_q_lo  <= in_dout;
                    r_state <= S_Q_HI;
                end
                S_Q_HI: if (!in_empty) begin
                    r_i_out <= w_i_quant;
                    r_q_out <= w_q_quant;
                    r_state <= S_WRITE;
                end
                S_WRITE: if (!i_full && !q_full) begin
                    r_state <= S_I_LO;
                end
                default: r_state <= S_I_LO;
            endcase
        end
    end

endmodule
